// File: rtl/feed_array.sv
// Skewing row feeder for a systolic array edge: accepts full matrix rows and delays lane k by k cycles.
// Optional row counter output enabled by defining FEED_ARRAY_ROW_CNT_EN.
module feed_array #(
   parameter int unsigned SIZE     = 2,
   parameter int unsigned MAX_ROWS = 16,
   parameter int unsigned DATA_W   = 8,
   localparam int unsigned ROW_W   = $clog2(MAX_ROWS + 1)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           start_i,
   input  logic [ROW_W-1:0]               rows_i,
   input  logic                           row_valid_i,
   input  logic [SIZE-1:0][DATA_W-1:0]    row_data_i,
   output logic                           row_ready_o,
   output logic [SIZE-1:0][DATA_W-1:0]    array_data_o,
   output logic [SIZE-1:0]                array_en_o,
   output logic                           busy_o,
`ifdef FEED_ARRAY_ROW_CNT_EN
   output logic                           done_o,
   output logic [ROW_W-1:0]               row_cnt_o
`else
   output logic                           done_o
`endif
);

   localparam int unsigned FC_W = (SIZE > 1) ? $clog2(SIZE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [ROW_W-1:0]  remaining_q;
   logic [FC_W-1:0]   flush_cnt_q;
   logic              row_ready_q;
   logic              busy_q;
   logic              done_q;
   logic [ROW_W-1:0]  rows_clamp_d;
   logic              accept_d;

   // Oversized requests are limited to what the block is built for.
   always_comb begin
      rows_clamp_d = rows_i;
      if (rows_i > ROW_W'(MAX_ROWS)) begin
         rows_clamp_d = ROW_W'(MAX_ROWS);
      end
   end

   assign accept_d = row_valid_i & row_ready_q;

   // Control FSM; outputs are registered alongside the state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         flush_cnt_q <= '0;
         row_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  busy_q <= 1'b1;
                  if (rows_i == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q     <= S_LOAD;
                     remaining_q <= rows_clamp_d;
                     row_ready_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (accept_d) begin
                  remaining_q <= remaining_q - ROW_W'(1);
                  if (remaining_q == ROW_W'(1)) begin
                     state_q     <= S_FLUSH;
                     flush_cnt_q <= FC_W'(SIZE - 1);
                     row_ready_q <= 1'b0;
                  end
               end
            end
            S_FLUSH: begin
               if (flush_cnt_q == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  flush_cnt_q <= flush_cnt_q - FC_W'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q     <= S_IDLE;
               row_ready_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign row_ready_o = row_ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

   // Per-lane delay line of depth k+1; non-accept cycles enter as zero bubbles.
   for (genvar k = 0; k < SIZE; k++) begin : g_lane
      logic [DATA_W-1:0] dat_q [0:k];
      logic [k:0]        en_q;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int d = 0; d <= k; d++) begin
               dat_q[d] <= '0;
            end
            en_q <= '0;
         end else begin
            dat_q[0] <= accept_d ? row_data_i[k] : '0;
            en_q[0]  <= accept_d;
            for (int d = 1; d <= k; d++) begin
               dat_q[d] <= dat_q[d-1];
               en_q[d]  <= en_q[d-1];
            end
         end
      end

      assign array_data_o[k] = dat_q[k];
      assign array_en_o[k]   = en_q[k];
   end

`ifdef FEED_ARRAY_ROW_CNT_EN
   logic [ROW_W-1:0] row_cnt_q;

   // Rows taken for the current matrix; held once loading ends.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         row_cnt_q <= '0;
      end else if (state_q == S_IDLE && start_i) begin
         row_cnt_q <= '0;
      end else if (accept_d) begin
         row_cnt_q <= row_cnt_q + ROW_W'(1);
      end
   end

   assign row_cnt_o = row_cnt_q;
`endif

endmodule

// File: tb/tb_feed_array.sv
// Bench for feed_array (SIZE=4): cycle-schedule model compared every cycle plus literal timing checks.
module tb_feed_array;

   localparam int SIZE = 4;
   localparam int DW   = 8;
   localparam int MR   = 16;
   localparam int RW   = $clog2(MR + 1);
   localparam int NCYC = 1024;

   logic                    clk;
   logic                    rst_i;
   logic                    start_i;
   logic [RW-1:0]           rows_i;
   logic                    row_valid_i;
   logic [SIZE-1:0][DW-1:0] row_data_i;
   logic                    row_ready_o;
   logic [SIZE-1:0][DW-1:0] array_data_o;
   logic [SIZE-1:0]         array_en_o;
   logic                    busy_o;
   logic                    done_o;
`ifdef FEED_ARRAY_ROW_CNT_EN
   logic [RW-1:0]           row_cnt_o;
`endif

   feed_array #(.SIZE(SIZE), .MAX_ROWS(MR), .DATA_W(DW)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .rows_i       (rows_i),
      .row_valid_i  (row_valid_i),
      .row_data_i   (row_data_i),
      .row_ready_o  (row_ready_o),
      .array_data_o (array_data_o),
      .array_en_o   (array_en_o),
      .busy_o       (busy_o),
`ifdef FEED_ARRAY_ROW_CNT_EN
      .done_o       (done_o),
      .row_cnt_o    (row_cnt_o)
`else
      .done_o       (done_o)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   // Model: a record of what entered the array edge each cycle, plus a few schedule numbers.
   logic            hist_en [NCYC];
   logic [31:0]     hist_d  [NCYC];
   logic            m_ready = 1'b0;
   int              m_rem   = 0;
   int              m_done  = -1;
   int              m_cnt   = 0;
   logic            m_valid = 1'b0;

   logic            obs_ready [NCYC];
   logic            obs_busy  [NCYC];
   logic            obs_done  [NCYC];
   logic [3:0]      obs_en    [NCYC];
   logic [31:0]     obs_d     [NCYC];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // One cycle: compare at negedge, then advance the model with this cycle's inputs.
   task automatic step();
      logic [3:0]  e_en;
      logic [31:0] e_d;
      int          t;
      int          n;
      @(negedge clk);
      if (cyc >= NCYC - 8) begin
         $display("FAIL cycle_budget cyc=%0d got=overrun want=<%0d", cyc, NCYC - 8);
         $fatal(1, "cycle budget exceeded");
      end
      obs_ready[cyc] = row_ready_o;
      obs_busy[cyc]  = busy_o;
      obs_done[cyc]  = done_o;
      obs_en[cyc]    = array_en_o;
      obs_d[cyc]     = array_data_o;
      if (m_valid) begin
         e_en = '0;
         e_d  = '0;
         for (int k = 0; k < SIZE; k++) begin
            t = cyc - 1 - k;
            if (t >= 0) begin
               e_en[k]        = hist_en[t];
               e_d[k*DW +: DW] = hist_d[t][k*DW +: DW];
            end
         end
         chk("row_ready", 64'(row_ready_o), 64'(m_ready));
         chk("busy", 64'(busy_o), 64'(m_ready || (cyc <= m_done)));
         chk("done", 64'(done_o), 64'(cyc == m_done));
         chk("array_en", 64'(array_en_o), 64'(e_en));
         chk("array_data", 64'(array_data_o), 64'(e_d));
`ifdef FEED_ARRAY_ROW_CNT_EN
         chk("row_cnt", 64'(row_cnt_o), 64'(m_cnt));
`endif
      end
      @(posedge clk);
      if (rst_i) begin
         m_valid = 1'b1;
         m_ready = 1'b0;
         m_rem   = 0;
         m_done  = -1;
         m_cnt   = 0;
         for (int i = cyc - SIZE; i <= cyc; i++) begin
            if (i >= 0) begin
               hist_en[i] = 1'b0;
               hist_d[i]  = '0;
            end
         end
      end else begin
         hist_en[cyc] = m_ready && row_valid_i;
         hist_d[cyc]  = (m_ready && row_valid_i) ? 32'(row_data_i) : 32'h0;
         if (m_ready && row_valid_i) begin
            m_rem--;
            m_cnt++;
            if (m_rem == 0) begin
               m_ready = 1'b0;
               m_done  = cyc + SIZE + 1;
            end
         end else if (!m_ready && cyc > m_done && start_i) begin
            n     = (int'(rows_i) > MR) ? MR : int'(rows_i);
            m_cnt = 0;
            if (n == 0) begin
               m_done = cyc + 1;
            end else begin
               m_rem   = n;
               m_ready = 1'b1;
            end
         end
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      start_i     = 1'b0;
      row_valid_i = 1'b0;
      row_data_i  = '0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drive(input logic st, input int rows, input logic v, input logic [31:0] d);
      start_i     = st;
      rows_i      = RW'(rows);
      row_valid_i = v;
      row_data_i  = d;
      step();
   endtask

   localparam logic [31:0] ROW_A = 32'h13121110;
   localparam logic [31:0] ROW_B = 32'h23222120;
   localparam logic [31:0] ROW_C = 32'h33323130;

   initial begin
      int b;
      int cnt;
      logic [31:0] va;
      logic [31:0] vb;
      for (int i = 0; i < NCYC; i++) begin
         hist_en[i] = 1'b0;
         hist_d[i]  = '0;
      end
      rst_i = 1'b1;
      start_i = 1'b0;
      rows_i = '0;
      row_valid_i = 1'b0;
      row_data_i = '0;
      step();
      step();
      rst_i = 1'b0;
      chk("reset_outputs", {60'(array_data_o), row_ready_o, busy_o, done_o, |array_en_o}, 64'h0);
      idle(2);

      // Back-to-back rows
      b = cyc;
      drive(1'b1, 2, 1'b0, 32'h0);
      drive(1'b0, 0, 1'b1, ROW_A);
      drive(1'b0, 0, 1'b1, ROW_B);
      idle(9);
      chk("b2b_lane0_A", {obs_en[b+2][0], obs_d[b+2][7:0]}, {1'b1, 8'h10});
      chk("b2b_lane0_B", {obs_en[b+3][0], obs_d[b+3][7:0]}, {1'b1, 8'h20});
      chk("b2b_lane3_A", {obs_en[b+5][3], obs_d[b+5][31:24]}, {1'b1, 8'h13});
      chk("b2b_lane3_B", {obs_en[b+6][3], obs_d[b+6][31:24]}, {1'b1, 8'h23});
      chk("b2b_done", {obs_done[b+6], obs_done[b+7], obs_done[b+8]}, 3'b010);
      chk("b2b_busy", {obs_busy[b], obs_busy[b+1], obs_busy[b+7], obs_busy[b+8]}, 4'b0110);

      // Bubble between two rows; idle-slot data must be gated to zero
      b = cyc;
      drive(1'b1, 2, 1'b0, 32'h0);
      drive(1'b0, 0, 1'b1, ROW_A);
      drive(1'b0, 0, 1'b0, 32'hFFFFFFFF);
      drive(1'b0, 0, 1'b1, ROW_B);
      idle(9);
      for (int k = 0; k < SIZE; k++) begin
         va = obs_d[b+2+k];
         vb = obs_d[b+3+k];
         chk("bubble_en_pattern", {obs_en[b+2+k][k], obs_en[b+3+k][k], obs_en[b+4+k][k]}, 3'b101);
         chk("bubble_slot_data", 64'(vb[k*DW +: DW]), 64'h0);
         chk("bubble_A_data", 64'(va[k*DW +: DW]), 64'(8'h10 + 8'(k)));
      end
      chk("bubble_done", 64'(obs_done[b+8]), 64'h1);

      // Zero rows
      b = cyc;
      drive(1'b1, 0, 1'b1, ROW_C);
      idle(4);
      chk("zero_done", {obs_done[b+1], obs_busy[b+1], obs_busy[b+2]}, 3'b110);
      chk("zero_no_ready_en", {obs_ready[b+1], obs_ready[b+2], |obs_en[b+2], |obs_en[b+3]}, 4'b0000);

      // Reset mid-operation, then a fresh matrix
      b = cyc;
      drive(1'b1, 3, 1'b0, 32'h0);
      drive(1'b0, 0, 1'b1, ROW_A);
      drive(1'b0, 0, 1'b1, ROW_B);
      rst_i = 1'b1;
      drive(1'b0, 0, 1'b1, ROW_C);
      rst_i = 1'b0;
      drive(1'b0, 0, 1'b0, 32'h0);
      drive(1'b1, 1, 1'b0, 32'h0);
      drive(1'b0, 0, 1'b1, ROW_C);
      idle(8);
      chk("rst_outputs_zero", {obs_ready[b+4], obs_busy[b+4], obs_done[b+4], obs_en[b+4], obs_d[b+4]}, 64'h0);
      cnt = 0;
      for (int x = b + 4; x <= b + 10; x++) cnt += int'(obs_done[x]);
      chk("rst_no_done", 64'(cnt), 64'h0);
      chk("rst_restart_done", 64'(obs_done[b+11]), 64'h1);
      chk("rst_restart_lane3", {obs_en[b+10][3], obs_d[b+10][31:24]}, {1'b1, 8'h33});

      // Start pulsed while loading is ignored
      b = cyc;
      drive(1'b1, 2, 1'b0, 32'h0);
      drive(1'b1, 5, 1'b1, ROW_A);
      drive(1'b0, 0, 1'b1, ROW_B);
      drive(1'b0, 0, 1'b1, ROW_C);
      idle(8);
      chk("ign_done", {obs_done[b+7], obs_ready[b+3]}, 2'b10);
`ifdef FEED_ARRAY_ROW_CNT_EN
      chk("ign_row_cnt", 64'(row_cnt_o), 64'h2);
`endif

      // Row count clamp
      b = cyc;
      drive(1'b1, 20, 1'b0, 32'h0);
      for (int i = 1; i <= 20; i++) drive(1'b0, 0, 1'b1, {4{8'(i)}} + 32'h30201000);
      idle(6);
      cnt = 0;
      for (int x = b + 1; x <= b + 20; x++) cnt += int'(obs_ready[x]);
      chk("clamp_accepts", 64'(cnt), 64'd16);
      chk("clamp_done", {obs_done[b+20], obs_done[b+21]}, 2'b01);
      chk("clamp_last_lane3", {obs_en[b+20][3], obs_d[b+20][31:24]}, {1'b1, 8'h40});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
